// File: rtl/regfile_reader.sv
// Operand fetch stage: holds one decoded instruction and waits until its sources are not
// pending. It then reads the register file and presents the operands downstream.
module regfile_reader (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_raddr1,
   input  logic [7:0]  in_raddr2,
   input  logic [7:0]  in_waddr,
   input  logic        in_wen,
   input  logic [31:0] in_tag,
   output logic [7:0]  rf_raddr1,
   output logic [7:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   input  logic        wb_valid,
   input  logic [7:0]  wb_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rs1,
   output logic [31:0] out_rs2,
   output logic [31:0] out_tag,
   output logic [7:0]  out_waddr,
   output logic        out_wen,
   output logic        pending_any
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READ,
      ST_OUT
   } state_t;

   state_t       state;
   state_t       state_next;
   logic         accept;

   logic [7:0]   lat_raddr1;
   logic [7:0]   lat_raddr2;
   logic [7:0]   lat_waddr;
   logic         lat_wen;
   logic [31:0]  lat_tag;

   logic [255:0] pending;
   logic [255:0] wb_clear;
   logic [255:0] pending_eff;
   logic [255:0] pending_next;
   logic         set_en;
   logic         hazard;

   assign accept = in_valid && in_ready;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   // NOTE: combinational blocks assign a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (in_valid)  state_next = ST_WAIT;
         ST_WAIT: if (!hazard)   state_next = ST_READ;
         ST_READ:                state_next = ST_OUT;
         ST_OUT:  if (out_ready) state_next = in_valid ? ST_WAIT : ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      in_ready  = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
      out_valid = (state == ST_OUT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_raddr1 <= '0;
         lat_raddr2 <= '0;
         lat_waddr  <= '0;
         lat_wen    <= 1'b0;
         lat_tag    <= '0;
      end else if (accept) begin
         lat_raddr1 <= in_raddr1;
         lat_raddr2 <= in_raddr2;
         lat_waddr  <= in_waddr;
         lat_wen    <= in_wen;
         lat_tag    <= in_tag;
      end
   end

   assign rf_raddr1 = lat_raddr1;
   assign rf_raddr2 = lat_raddr2;

   // A same-cycle writeback is forwarded by the register file, so it already counts as not pending.
   always_comb begin
      wb_clear    = wb_valid ? (256'd1 << wb_addr) : '0;
      pending_eff = pending & ~wb_clear;
      hazard      = pending_eff[lat_raddr1] | pending_eff[lat_raddr2];
      set_en      = (state == ST_READ) && lat_wen && (lat_waddr[4:0] != 5'd0);
      pending_next = pending_eff;
      if (set_en) pending_next[lat_waddr] = 1'b1;
   end

   // NOTE: the scoreboard is a flop array holding live hazard state, not a RAM, so it is reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= pending_next;
   end

   assign pending_any = |pending;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_rs1   <= '0;
         out_rs2   <= '0;
         out_tag   <= '0;
         out_waddr <= '0;
         out_wen   <= 1'b0;
      end else if (state == ST_READ) begin
         out_rs1   <= rf_rdata1;
         out_rs2   <= rf_rdata2;
         out_tag   <= lat_tag;
         out_waddr <= lat_waddr;
         out_wen   <= lat_wen;
      end
   end

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader. It includes a registered register-file model with
// same-cycle write forwarding, and a monitor that pops expected results on each output handshake.
module tb_regfile_reader;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_raddr1;
   logic [7:0]  in_raddr2;
   logic [7:0]  in_waddr;
   logic        in_wen;
   logic [31:0] in_tag;
   logic [7:0]  rf_raddr1;
   logic [7:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        wb_valid;
   logic [7:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rs1;
   logic [31:0] out_rs2;
   logic [31:0] out_tag;
   logic [7:0]  out_waddr;
   logic        out_wen;
   logic        pending_any;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] tag;
      logic [7:0]  waddr;
      logic        wen;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   regfile_reader dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_raddr1  (in_raddr1),
      .in_raddr2  (in_raddr2),
      .in_waddr   (in_waddr),
      .in_wen     (in_wen),
      .in_tag     (in_tag),
      .rf_raddr1  (rf_raddr1),
      .rf_raddr2  (rf_raddr2),
      .rf_rdata1  (rf_rdata1),
      .rf_rdata2  (rf_rdata2),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_tag    (out_tag),
      .out_waddr  (out_waddr),
      .out_wen    (out_wen),
      .pending_any(pending_any)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Register file model: registered read, same-cycle write forwarded, re-initialised under reset.
   logic [31:0] regs [256];

   function automatic logic [31:0] rf_init(input int i);
      if (i == 3)               return 32'h1111_1111;
      else if (i == 4)          return 32'h2222_2222;
      else if ((i % 32) == 0)   return 32'h0000_0000;
      else                      return 32'hA000_0000 | 32'(i);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) regs[i] <= rf_init(i);
         rf_rdata1 <= '0;
         rf_rdata2 <= '0;
      end else begin
         rf_rdata1 <= (wb_valid && wb_addr == rf_raddr1) ? wb_data : regs[rf_raddr1];
         rf_rdata2 <= (wb_valid && wb_addr == rf_raddr2) ? wb_data : regs[rf_raddr2];
         if (wb_valid) regs[wb_addr] <= wb_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: compares every handshaken output against the head of the expectation queue.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("out_unexpected", {31'd0, out_valid}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_rs1", out_rs1, mon_e.rs1);
            check("out_rs2", out_rs2, mon_e.rs2);
            check("out_tag", out_tag, mon_e.tag);
            check("out_waddr_wen", {23'd0, out_waddr, out_wen}, {23'd0, mon_e.waddr, mon_e.wen});
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] wa,
                         input logic we, input logic [31:0] tag);
      in_raddr1 = r1;
      in_raddr2 = r2;
      in_waddr  = wa;
      in_wen    = we;
      in_tag    = tag;
   endtask

   // Push the expectation, hold in_valid until accepted, return one step after the accept edge.
   task automatic issue(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] wa,
                        input logic we, input logic [31:0] tag,
                        input logic [31:0] e1, input logic [31:0] e2);
      int waited;
      exp_q.push_back('{rs1: e1, rs2: e2, tag: tag, waddr: wa, wen: we});
      set_in(r1, r2, wa, we, tag);
      in_valid = 1'b1;
      waited = 0;
      #1;
      while (!in_ready && waited < 50) begin
         @(posedge clock);
         #2;
         waited++;
      end
      check("accept_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Checks out_valid over the cycles following an accept: n_idle low cycles, then one high.
   task automatic expect_latency(input int n_idle);
      for (int i = 0; i < n_idle; i++) begin
         @(negedge clock);
         check("lat_low", {31'd0, out_valid}, 32'd0);
         step();
      end
      @(negedge clock);
      check("lat_high", {31'd0, out_valid}, 32'd1);
      step();
   endtask

   task automatic wb_on(input logic [7:0] a, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      set_in(8'h00, 8'h00, 8'h00, 1'b0, 32'h0);
      wb_valid  = 1'b0;
      wb_addr   = 8'h00;
      wb_data   = 32'h0;
      out_ready = 1'b1;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_pending_any", {31'd0, pending_any}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_rs1", out_rs1, 32'd0);
      check("rst_out_tag", out_tag, 32'd0);
      check("rst_rf_raddr1", {24'd0, rf_raddr1}, 32'd0);
      step();

      // Accept on the first edge after reset deasserts; result three cycles later.
      reset = 1'b0;
      issue(8'h03, 8'h04, 8'h00, 1'b0, 32'hCAFE_0001, 32'h1111_1111, 32'h2222_2222);
      check("rf_raddr1_drive", {24'd0, rf_raddr1}, 32'h03);
      check("rf_raddr2_drive", {24'd0, rf_raddr2}, 32'h04);
      expect_latency(2);

      // RAW hazard on 0x05 stalls until the writeback of 0x05.
      issue(8'h01, 8'h02, 8'h05, 1'b1, 32'hCAFE_0002, 32'hA000_0001, 32'hA000_0002);
      wait_drain();
      check("pend_after_w5", {31'd0, pending_any}, 32'd1);
      issue(8'h05, 8'h00, 8'h00, 1'b0, 32'hCAFE_0003, 32'hDEAD_0005, 32'h0000_0000);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("stall_out_valid", {31'd0, out_valid}, 32'd0);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      wb_on(8'h05, 32'hDEAD_0005);
      step();
      wb_valid = 1'b0;
      expect_latency(1);
      check("pend_cleared_5", {31'd0, pending_any}, 32'd0);

      // Writeback arrives in the very cycle the dependent WAIT begins: no stall.
      issue(8'h06, 8'h07, 8'h05, 1'b1, 32'hCAFE_0004, 32'hA000_0006, 32'hA000_0007);
      wait_drain();
      issue(8'h05, 8'h00, 8'h0B, 1'b0, 32'hCAFE_0005, 32'hBEEF_0005, 32'h0000_0000);
      wb_on(8'h05, 32'hBEEF_0005);
      step();
      wb_valid = 1'b0;
      expect_latency(1);
      check("pend_cleared_5b", {31'd0, pending_any}, 32'd0);

      // Downstream back-pressure: outputs stay stable, then accept on the release cycle.
      out_ready = 1'b0;
      issue(8'h03, 8'h04, 8'h0C, 1'b0, 32'hCAFE_0006, 32'h1111_1111, 32'h2222_2222);
      step();
      step();
      set_in(8'h01, 8'h02, 8'h0D, 1'b0, 32'hCAFE_0007);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("hold_out_rs1", out_rs1, 32'h1111_1111);
         check("hold_out_rs2", out_rs2, 32'h2222_2222);
         check("hold_out_tag", out_tag, 32'hCAFE_0006);
         step();
      end
      exp_q.push_back('{rs1: 32'hA000_0001, rs2: 32'hA000_0002, tag: 32'hCAFE_0007,
                        waddr: 8'h0D, wen: 1'b0});
      out_ready = 1'b1;
      #1;
      check("release_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      expect_latency(2);

      // Register 0 of any hart is never marked pending.
      issue(8'h01, 8'h02, 8'h20, 1'b1, 32'hCAFE_0008, 32'hA000_0001, 32'hA000_0002);
      wait_drain();
      check("pend_zero_reg", {31'd0, pending_any}, 32'd0);

      // Set and writeback-clear of 0x07 in the same cycle: set wins.
      issue(8'h01, 8'h02, 8'h07, 1'b1, 32'hCAFE_0009, 32'hA000_0001, 32'hA000_0002);
      step();
      wb_on(8'h07, 32'h0707_0707);
      step();
      wb_valid = 1'b0;
      @(negedge clock);
      check("set_wins_pend", {31'd0, pending_any}, 32'd1);
      step();
      issue(8'h07, 8'h00, 8'h0E, 1'b0, 32'hCAFE_000A, 32'h7777_0007, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("stall7_out_valid", {31'd0, out_valid}, 32'd0);
         step();
      end
      wb_on(8'h07, 32'h7777_0007);
      step();
      wb_valid = 1'b0;
      wait_drain();
      check("pend_cleared_7", {31'd0, pending_any}, 32'd0);

      // Reset while stalled in WAIT with a pending bit set.
      issue(8'h01, 8'h02, 8'h0A, 1'b1, 32'hCAFE_000B, 32'hA000_0001, 32'hA000_0002);
      wait_drain();
      check("pend_set_0a", {31'd0, pending_any}, 32'd1);
      issue(8'h0A, 8'h00, 8'h00, 1'b0, 32'hCAFE_000C, 32'hA000_000A, 32'h0000_0000);
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_pending_any", {31'd0, pending_any}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.delete();
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
         step();
      end

      issue(8'h03, 8'h04, 8'h00, 1'b0, 32'hCAFE_000D, 32'h1111_1111, 32'h2222_2222);
      expect_latency(2);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001: clock  in  1  single clock; all state updates on its rising edge.
REQ-002: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-003: in_valid  in  1  upstream has a decoded instruction.
REQ-004: in_ready  out  1  block accepts the instruction this cycle.
REQ-005: in_raddr1, in_raddr2  in  8 each  source register addresses (hart in [7:5], register in [4:0]).
REQ-006: in_waddr  in  8  destination register address; in_wen  in  1  instruction writes in_waddr.
REQ-007: in_tag  in  32  opaque payload (pc/insn), passed through unchanged.
REQ-008: rf_raddr1, rf_raddr2  out  8 each  register file read addresses.
REQ-009: rf_rdata1, rf_rdata2  in  32 each  register file read data, registered, valid one cycle after address.
REQ-010: wb_valid  in  1  writeback to register file occurs this cycle; wb_addr  in  8  its address.
REQ-011: out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-012: out_rs1, out_rs2  out  32 each; out_tag  out  32; out_waddr  out  8; out_wen  out  1  fetched operands and passed-through fields.
REQ-013: pending_any  out  1  at least one scoreboard bit set.

Function
REQ-014: Block SHALL implement states IDLE, WAIT, READ, OUT with at most one instruction in flight.
REQ-015: in_ready SHALL be 1 in IDLE, and in OUT when out_ready=1; 0 otherwise.
REQ-016: On in_valid && in_ready, block SHALL latch raddr1/raddr2/waddr/wen/tag and enter WAIT next cycle.
REQ-017: rf_raddr1/rf_raddr2 SHALL be driven combinationally from the latched addresses in every state.
REQ-018: Block SHALL keep a 256-bit pending scoreboard, one bit per register address.
REQ-019: In WAIT, hazard = (pending[raddr1] or pending[raddr2]), where a bit whose address equals wb_addr with wb_valid=1 in the same cycle counts as not pending (the register file forwards same-cycle writes).
REQ-020: WAIT with hazard SHALL remain in WAIT; WAIT without hazard SHALL go to READ next cycle.
REQ-021: In READ, block SHALL capture rf_rdata1/rf_rdata2 into out_rs1/out_rs2, set pending[waddr] if wen=1, and enter OUT.
REQ-022: Addresses with [4:0]=0 SHALL never be marked pending (hardwired zero register).
REQ-023: In OUT, out_valid SHALL be 1 and out_* SHALL be stable until out_ready=1; then go to IDLE, or to WAIT if a new instruction is accepted that cycle.
REQ-024: wb_valid=1 SHALL clear pending[wb_addr]; a clear of a non-pending bit SHALL have no effect.
REQ-025: Set and clear of the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-026: Minimum latency accept-to-out_valid SHALL be 3 cycles; back-to-back throughput one instruction per 3 cycles without hazards.
REQ-027: pending_any SHALL be the OR-reduction of the registered scoreboard.

Reset
REQ-028: Reset SHALL force state IDLE, scoreboard all 0, latched fields 0, out_rs1/out_rs2/out_tag/out_waddr 0, out_wen 0, out_valid 0.
REQ-029: Reset asserted mid-operation SHALL discard the in-flight instruction; no partial output SHALL appear after deassertion.
REQ-030: First accept SHALL be possible in the first clock edge after reset deasserts.

Verification
REQ-031: Reset, accept raddr1=0x03, raddr2=0x04 with rf model holding 0x11111111/0x22222222 -> out_valid 3 cycles later, out_rs1=0x11111111, out_rs2=0x22222222.
REQ-032: Accept waddr=0x05 wen=1, drain; accept raddr1=0x05 -> stall in WAIT until wb_valid wb_addr=0x05, then out_rs1 equals written data.
REQ-033: wb_valid wb_addr=0x05 in the same cycle the dependent WAIT begins -> no stall cycle, forwarded data returned.
REQ-034: Hold out_ready=0 for 5 cycles -> out_* stable, in_ready=0; then out_ready=1 with in_valid=1 -> new instruction accepted same cycle.
REQ-035: Instruction with waddr=0x20 wen=1 -> pending_any stays 0; same-cycle set and wb clear of 0x07 -> pending[0x07]=1.
REQ-036: Assert reset while in WAIT with pending bits set -> out_valid=0, pending_any=0 immediately, in_ready=1 after deassertion.
